// File: rtl/apb_pad_ctrl_shadow.sv
// APB slave holding shadow pad mux/config registers, copied to the live pad outputs on commit.
// Also provides a sticky LOCK, an auto-increment INDEX/DATA port and PSLVERR reporting with a saturating error count.
module apb_pad_ctrl_shadow #(
  parameter int unsigned            APB_ADDR_WIDTH = 12,
  parameter int unsigned            N_IO           = 64,
  parameter int unsigned            NBIT_PADCFG    = 6,
  parameter int unsigned            NBIT_PADMUX    = 2,
  parameter logic [NBIT_PADCFG-1:0] PADCFG_RST     = '1
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0]     PADDR,
  input  logic [31:0]                   PWDATA,
  input  logic                          PWRITE,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  output logic [31:0]                   PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  input  logic                          commit_i,
  output logic [N_IO*NBIT_PADCFG-1:0]   pad_cfg_o,
  output logic [N_IO*NBIT_PADMUX-1:0]   pad_mux_o,
  output logic                          locked_o,
  output logic                          pending_o
);

  localparam int unsigned      IDX_W    = (N_IO > 1) ? $clog2(N_IO) : 1;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IO - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [11:0] A_INFO   = 12'h000;
  localparam logic [11:0] A_CTRL   = 12'h004;
  localparam logic [11:0] A_INDEX  = 12'h008;
  localparam logic [11:0] A_DATA   = 12'h00C;
  localparam logic [11:0] A_COMMIT = 12'h010;
  localparam logic [11:0] A_STATUS = 12'h014;

  logic [1:0]             state_q;
  logic                   lock_q;
  logic                   autoinc_q;
  logic                   pending_q;
  logic [7:0]             errcnt_q;
  logic [IDX_W-1:0]       index_q;
  logic [NBIT_PADCFG-1:0] sh_cfg [N_IO];
  logic [NBIT_PADMUX-1:0] sh_mux [N_IO];
  logic [NBIT_PADCFG-1:0] lv_cfg [N_IO];
  logic [NBIT_PADMUX-1:0] lv_mux [N_IO];

  logic [11:0]      off;
  logic [7:0]       win_i;
  logic             in_win;
  logic             win_ok;
  logic             index_ok;
  logic [IDX_W-1:0] pad_sel;
  logic [31:0]      pad_word;
  logic [31:0]      rdata;
  logic             err;
  logic             sh_we;
  logic             ctrl_we;
  logic             idx_we;
  logic             cm_apb;
  logic             inc;
  logic             acc;
  logic             sh_do;
  logic             commit;

  assign off      = PADDR[11:0];
  assign win_i    = off[9:2];
  assign in_win   = (off[11:10] == 2'b01) && (off[1:0] == 2'b00);
  assign win_ok   = 32'(win_i) < N_IO;
  assign index_ok = 32'(index_q) < N_IO;
  assign acc      = (state_q == ST_ACCESS);
  assign sh_do    = acc && sh_we;
  // Hardware commit is independent of LOCK and of the APB FSM.
  assign commit   = commit_i || (acc && cm_apb);

  always_comb begin
    err      = 1'b0;
    rdata    = '0;
    sh_we    = 1'b0;
    ctrl_we  = 1'b0;
    idx_we   = 1'b0;
    cm_apb   = 1'b0;
    inc      = 1'b0;
    pad_sel  = in_win ? win_i[IDX_W-1:0] : index_q;
    pad_word = '0;
    pad_word[8 +: NBIT_PADCFG] = sh_cfg[pad_sel];
    pad_word[0 +: NBIT_PADMUX] = sh_mux[pad_sel];
    if (in_win) begin
      if (!win_ok || (PWRITE && lock_q)) err = 1'b1;
      else if (PWRITE)                   sh_we = 1'b1;
      else                               rdata = pad_word;
    end else begin
      case (off)
        A_INFO:   if (PWRITE) err = 1'b1;
                  else rdata = {16'(N_IO), 8'(NBIT_PADMUX), 8'(NBIT_PADCFG)};
        A_CTRL:   if (PWRITE) ctrl_we = 1'b1;
                  else rdata = {30'b0, autoinc_q, lock_q};
        A_INDEX:  if (!PWRITE) rdata = 32'(index_q);
                  else if (lock_q || (PWDATA >= N_IO)) err = 1'b1;
                  else idx_we = 1'b1;
        A_DATA: begin
          if (!index_ok || (PWRITE && lock_q)) err = 1'b1;
          else begin
            inc = autoinc_q;
            if (PWRITE) sh_we = 1'b1;
            else        rdata = pad_word;
          end
        end
        A_COMMIT: if (PWRITE) begin
                    if (lock_q) err = 1'b1;
                    else        cm_apb = PWDATA[0];
                  end
        A_STATUS: if (PWRITE) err = 1'b1;
                  else rdata = {16'b0, errcnt_q, 6'b0, lock_q, pending_q};
        default:  err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      PRDATA    <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      lock_q    <= 1'b0;
      autoinc_q <= 1'b0;
      pending_q <= 1'b0;
      errcnt_q  <= '0;
      index_q   <= '0;
      for (int unsigned i = 0; i < N_IO; i++) begin
        sh_cfg[i] <= PADCFG_RST;
        sh_mux[i] <= '0;
        lv_cfg[i] <= PADCFG_RST;
        lv_mux[i] <= '0;
      end
    end else begin
      // Live copies the pre-edge shadow, so a same-edge write stays pending.
      if (commit) begin
        for (int unsigned i = 0; i < N_IO; i++) begin
          lv_cfg[i] <= sh_cfg[i];
          lv_mux[i] <= sh_mux[i];
        end
      end
      if (sh_do) begin
        sh_cfg[pad_sel] <= PWDATA[8 +: NBIT_PADCFG];
        sh_mux[pad_sel] <= PWDATA[0 +: NBIT_PADMUX];
      end
      if (sh_do)       pending_q <= 1'b1;
      else if (commit) pending_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          PREADY <= 1'b0;
          if (PSEL && PENABLE) state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          PREADY  <= 1'b1;
          PSLVERR <= err;
          PRDATA  <= err ? '0 : rdata;
          state_q <= ST_DONE;
          if (err && (errcnt_q != 8'hFF)) errcnt_q <= errcnt_q + 8'd1;
          if (ctrl_we) begin
            lock_q    <= lock_q | PWDATA[0];
            autoinc_q <= PWDATA[1];
          end
          if (idx_we) index_q <= PWDATA[IDX_W-1:0];
          else if (inc) index_q <= (index_q == IDX_LAST) ? '0 : index_q + IDX_ONE;
        end
        default: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_IO; g++) begin : g_pad
    assign pad_cfg_o[g*NBIT_PADCFG +: NBIT_PADCFG] = lv_cfg[g];
    assign pad_mux_o[g*NBIT_PADMUX +: NBIT_PADMUX] = lv_mux[g];
  end

  assign locked_o  = lock_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_apb_pad_ctrl_shadow.sv
// Directed bench for apb_pad_ctrl_shadow: register-level model of the pad block checked every cycle,
// plus literal expectations that pin the model to known values.
module tb_apb_pad_ctrl_shadow;
  localparam int N  = 64;
  localparam int NC = 6;
  localparam int NM = 2;

  logic            HCLK = 1'b0;
  logic            HRESETn = 1'b0;
  logic [11:0]     PADDR = '0;
  logic [31:0]     PWDATA = '0;
  logic            PWRITE = 1'b0;
  logic            PSEL = 1'b0;
  logic            PENABLE = 1'b0;
  logic [31:0]     PRDATA;
  logic            PREADY;
  logic            PSLVERR;
  logic            commit_i = 1'b0;
  logic [N*NC-1:0] pad_cfg_o;
  logic [N*NM-1:0] pad_mux_o;
  logic            locked_o;
  logic            pending_o;

  always #5 HCLK = ~HCLK;

  apb_pad_ctrl_shadow #(
    .APB_ADDR_WIDTH(12),
    .N_IO(N),
    .NBIT_PADCFG(NC),
    .NBIT_PADMUX(NM)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .commit_i(commit_i), .pad_cfg_o(pad_cfg_o), .pad_mux_o(pad_mux_o),
    .locked_o(locked_o), .pending_o(pending_o)
  );

  int checks = 0;
  int errors = 0;

  int m_cfg_sh [N];
  int m_mux_sh [N];
  int m_cfg_lv [N];
  int m_mux_lv [N];
  bit m_lock, m_ainc, m_pend;
  int m_idx, m_errcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cfg_sh[i] = 63; m_mux_sh[i] = 0; m_cfg_lv[i] = 63; m_mux_lv[i] = 0;
    end
    m_lock = 0; m_ainc = 0; m_pend = 0; m_idx = 0; m_errcnt = 0;
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < N; i++) begin
      m_cfg_lv[i] = m_cfg_sh[i];
      m_mux_lv[i] = m_mux_sh[i];
    end
    m_pend = 0;
  endfunction

  // Register map semantics: result of one APB access and its side effects.
  function automatic void model_access(input bit wr, input int unsigned a, input int unsigned d,
                                       output bit err, output int unsigned rd, output bit cm);
    int unsigned pad;
    bit is_pad, inc;
    err = 0; rd = 0; cm = 0; inc = 0; pad = 0; is_pad = 0;
    if (a >= 'h400 && a < 'h800 && a % 4 == 0) begin
      is_pad = 1; pad = (a - 'h400) / 4;
    end else if (a == 'h00C) begin
      is_pad = 1; pad = m_idx; inc = m_ainc;
    end
    if (is_pad) begin
      if (pad >= N || (wr && m_lock)) err = 1;
      else if (wr) begin
        m_cfg_sh[pad] = (d >> 8) % 64;
        m_mux_sh[pad] = d % 4;
        m_pend = 1;
      end else rd = m_cfg_sh[pad] * 256 + m_mux_sh[pad];
    end else begin
      case (a)
        'h000: if (wr) err = 1; else rd = N * 65536 + NM * 256 + NC;
        'h004: if (wr) begin m_lock = m_lock || d[0]; m_ainc = d[1]; end
               else rd = m_ainc * 2 + m_lock;
        'h008: if (!wr) rd = m_idx; else if (m_lock || d >= N) err = 1; else m_idx = d;
        'h010: if (wr) begin if (m_lock) err = 1; else cm = d[0]; end
        'h014: if (wr) err = 1; else rd = m_errcnt * 256 + m_lock * 2 + m_pend;
        default: err = 1;
      endcase
    end
    if (!err && inc) m_idx = (m_idx + 1) % N;
    if (err && m_errcnt < 255) m_errcnt++;
  endfunction

  task automatic xfer(input bit wr, input int unsigned a, input int unsigned d,
                      input bit hw_commit, output int unsigned rd);
    bit e_err, e_cm;
    int unsigned e_rd;
    int cyc;
    @(negedge HCLK);
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a[11:0]; PWDATA = d;
    @(negedge HCLK);
    PENABLE = 1;
    cyc = 0;
    do begin
      @(posedge HCLK); #1;
      cyc++;
      if (hw_commit && cyc == 1) commit_i = 1;
    end while (!PREADY && cyc < 10);
    chk("wait_states", cyc, 2);
    if (hw_commit) begin
      commit_i = 0;
      model_commit();
    end
    model_access(wr, a, d, e_err, e_rd, e_cm);
    if (e_cm) model_commit();
    chk("pslverr", PSLVERR, e_err);
    chk("prdata", PRDATA, e_rd);
    rd = PRDATA;
    @(negedge HCLK);
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic pulse_commit();
    @(negedge HCLK);
    commit_i = 1;
    @(posedge HCLK); #1;
    commit_i = 0;
    model_commit();
  endtask

  logic [N*NC-1:0] exp_cfg;
  logic [N*NM-1:0] exp_mux;

  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESETn) begin
        for (int i = 0; i < N; i++) begin
          exp_cfg[i*NC +: NC] = NC'(m_cfg_lv[i]);
          exp_mux[i*NM +: NM] = NM'(m_mux_lv[i]);
        end
        checks++;
        if (pad_cfg_o !== exp_cfg) begin
          errors++;
          $display("FAIL live_cfg: got %h expected %h", pad_cfg_o, exp_cfg);
        end
        checks++;
        if (pad_mux_o !== exp_mux) begin
          errors++;
          $display("FAIL live_mux: got %h expected %h", pad_mux_o, exp_mux);
        end
        chk("locked_o", 32'(locked_o), 32'(m_lock));
        chk("pending_o", 32'(pending_o), 32'(m_pend));
      end
    end
  end

  initial begin
    int unsigned rd;
    int cyc;
    model_reset();
    repeat (3) @(negedge HCLK);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pready", 32'(PREADY), 32'h0);
    chk("rst_pslverr", 32'(PSLVERR), 32'h0);
    checks++;
    if (pad_cfg_o !== {(N*NC){1'b1}}) begin
      errors++;
      $display("FAIL rst_cfg: got %h expected all ones", pad_cfg_o);
    end
    checks++;
    if (pad_mux_o !== '0) begin
      errors++;
      $display("FAIL rst_mux: got %h expected 0", pad_mux_o);
    end
    HRESETn = 1;

    xfer(0, 'h000, 0, 0, rd);
    chk("info_lit", rd, 32'h0040_0206);

    xfer(1, 'h414, 32'h0000_2A03, 0, rd);
    chk("pad5_mux_pre", 32'(pad_mux_o[10 +: 2]), 32'h0);
    chk("pend_after_wr", 32'(pending_o), 32'h1);
    xfer(1, 'h010, 1, 0, rd);
    chk("pad5_cfg_lit", 32'(pad_cfg_o[30 +: 6]), 32'h2A);
    chk("pad5_mux_lit", 32'(pad_mux_o[10 +: 2]), 32'h3);
    chk("pend_after_cm", 32'(pending_o), 32'h0);
    xfer(0, 'h414, 0, 0, rd);

    xfer(1, 'h004, 2, 0, rd);
    xfer(1, 'h008, 62, 0, rd);
    xfer(1, 'h00C, 'h101, 0, rd);
    xfer(1, 'h00C, 'h102, 0, rd);
    xfer(1, 'h00C, 'h103, 0, rd);
    xfer(0, 'h008, 0, 0, rd);
    chk("index_wrap_lit", rd, 32'd1);
    xfer(0, 'h400, 0, 0, rd);
    chk("pad0_lit", rd, 32'h103);
    xfer(0, 'h4F8, 0, 0, rd);
    xfer(0, 'h4FC, 0, 0, rd);
    xfer(0, 'h00C, 0, 0, rd);
    chk("data_rd_pad1_lit", rd, 32'h3F00);

    xfer(0, 'h500, 0, 0, rd);
    xfer(1, 'h008, 70, 0, rd);
    xfer(0, 'h008, 0, 0, rd);
    chk("index_kept_lit", rd, 32'd2);
    xfer(0, 'h014, 0, 0, rd);
    chk("errcnt2_lit", (rd >> 8) & 32'hFF, 32'd2);
    xfer(1, 'h010, 0, 0, rd);
    xfer(0, 'h010, 0, 0, rd);
    xfer(1, 'h000, 5, 0, rd);
    xfer(1, 'h014, 5, 0, rd);
    xfer(0, 'h018, 0, 0, rd);
    xfer(0, 'h402, 0, 0, rd);

    xfer(1, 'h40C, 32'h0000_1501, 1, rd);
    chk("pad3_cfg_old_lit", 32'(pad_cfg_o[18 +: 6]), 32'h3F);
    chk("pend_same_edge", 32'(pending_o), 32'h1);
    pulse_commit();
    @(negedge HCLK);
    chk("pad3_cfg_new_lit", 32'(pad_cfg_o[18 +: 6]), 32'h15);
    chk("pad3_mux_new_lit", 32'(pad_mux_o[6 +: 2]), 32'h1);

    xfer(1, 'h41C, 32'h0000_0702, 0, rd);
    xfer(1, 'h004, 1, 0, rd);
    chk("lock_set_lit", 32'(locked_o), 32'h1);
    xfer(1, 'h00C, 'h1234, 0, rd);
    xfer(1, 'h004, 0, 0, rd);
    chk("lock_sticky_lit", 32'(locked_o), 32'h1);
    xfer(1, 'h010, 1, 0, rd);
    xfer(1, 'h008, 3, 0, rd);
    xfer(1, 'h41C, 'h3F03, 0, rd);
    xfer(0, 'h41C, 0, 0, rd);
    pulse_commit();
    @(negedge HCLK);
    chk("pad7_cfg_lit", 32'(pad_cfg_o[42 +: 6]), 32'h7);
    chk("pad7_mux_lit", 32'(pad_mux_o[14 +: 2]), 32'h2);
    chk("pend_locked_cm", 32'(pending_o), 32'h0);

    for (int i = 0; i < 260; i++) xfer(0, 'h018, 0, 0, rd);
    xfer(0, 'h014, 0, 0, rd);
    chk("errcnt_sat_lit", (rd >> 8) & 32'hFF, 32'd255);

    @(negedge HCLK);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 12'h000;
    @(negedge HCLK);
    PENABLE = 1;
    cyc = 0;
    do begin
      @(posedge HCLK); #1;
      cyc++;
    end while (!PREADY && cyc < 10);
    chk("mid_wait_states", cyc, 2);
    HRESETn = 0;
    model_reset();
    #1;
    chk("mid_rst_pready", 32'(PREADY), 32'h0);
    chk("mid_rst_prdata", PRDATA, 32'h0);
    chk("mid_rst_locked", 32'(locked_o), 32'h0);
    checks++;
    if (pad_cfg_o !== {(N*NC){1'b1}}) begin
      errors++;
      $display("FAIL mid_rst_cfg: got %h expected all ones", pad_cfg_o);
    end
    PSEL = 0; PENABLE = 0;
    @(negedge HCLK);
    HRESETn = 1;
    xfer(0, 'h014, 0, 0, rd);
    chk("status_after_rst_lit", rd, 32'h0);
    xfer(0, 'h004, 0, 0, rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
